// File: rtl/psram_pkg.sv
// Shared types for the bridge-to-PSRAM write path: FSM states, FIFO entry
// layout and the PSRAM word-address width.
package psram_pkg;

  localparam int PSRAM_WORD_AW = 23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } wr_state_t;

  typedef struct packed {
    logic [21:0] addr;
    logic [31:0] data;
  } fifo_entry_t;

  localparam int FIFO_ENTRY_W = 54;

  function automatic logic [15:0] byteswap16(input logic [15:0] h);
    return {h[7:0], h[15:8]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count, full/empty flags and
// show-ahead read data (pop_data is the head entry whenever !empty).
module sync_fifo #(
  parameter int WIDTH = 54,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Full is judged on the registered count, so a same-cycle pop never frees space.
  assign full_s    = (count_r == (AW+1)'(DEPTH));
  assign empty_s   = (count_r == (AW+1)'(0));
  assign push_ok_s = push && !full_s;
  assign pop_ok_s  = pop && !empty_s;

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= (AW+1)'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign full     = full_s;
  assign empty    = empty_s;
  assign count    = count_r;

endmodule

// File: rtl/bridge_psram_writer.sv
// Turns APF bridge writes inside a 16 MiB window into low-then-high halfword
// PSRAM requests. Define BRIDGE_WR_BYTESWAP_EN to byte-swap each halfword.
module bridge_psram_writer
  import psram_pkg::*;
#(
  parameter logic [7:0] WINDOW_BASE = 8'h00,
  parameter int         FIFO_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     bridge_wr,
  input  logic [31:0]              bridge_addr,
  input  logic [31:0]              bridge_wr_data,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [PSRAM_WORD_AW-1:0] mem_addr,
  output logic [15:0]              mem_data,
  output logic                     busy,
  output logic                     overflow
);

  localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [15:0] half_fmt(input logic [15:0] h);
`ifdef BRIDGE_WR_BYTESWAP_EN
    return byteswap16(h);
`else
    return h;
`endif
  endfunction

  logic                     hit_s;
  logic                     unused_addr_bits_s;
  fifo_entry_t              push_entry_s;
  fifo_entry_t              head_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic [FIFO_CW-1:0]       fifo_count_s;
  logic                     pop_s;
  logic                     load_lo_s;
  logic                     load_hi_s;
  logic                     handshake_s;
  wr_state_t                state_r;
  wr_state_t                state_s;
  logic                     mem_valid_r;
  logic [PSRAM_WORD_AW-1:0] mem_addr_r;
  logic [15:0]              mem_data_r;
  logic [15:0]              hi_data_r;
  logic                     overflow_r;

  assign hit_s              = bridge_wr && (bridge_addr[31:24] == WINDOW_BASE);
  assign unused_addr_bits_s = ^bridge_addr[1:0];
  assign push_entry_s       = '{addr: bridge_addr[23:2], data: bridge_wr_data};
  assign handshake_s        = mem_valid_r && mem_ready;

  sync_fifo #(
    .WIDTH (FIFO_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (hit_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Next-state and load decode; HI chains straight into the next low half.
  always_comb begin
    state_s   = state_r;
    pop_s     = 1'b0;
    load_lo_s = 1'b0;
    load_hi_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s     = 1'b1;
          load_lo_s = 1'b1;
          state_s   = LO;
        end else begin
          state_s = IDLE;
        end
      end
      LO: begin
        if (handshake_s) begin
          load_hi_s = 1'b1;
          state_s   = HI;
        end else begin
          state_s = LO;
        end
      end
      HI: begin
        if (handshake_s && !fifo_empty_s) begin
          pop_s     = 1'b1;
          load_lo_s = 1'b1;
          state_s   = LO;
        end else if (handshake_s) begin
          state_s = IDLE;
        end else begin
          state_s = HI;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request registers; they only change on a load, so stalls hold them stable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_valid_r <= 1'b0;
      mem_addr_r  <= {PSRAM_WORD_AW{1'b0}};
      mem_data_r  <= 16'h0000;
      hi_data_r   <= 16'h0000;
    end else begin
      mem_valid_r <= (state_s != IDLE);
      if (load_lo_s) begin
        mem_addr_r <= {head_s.addr, 1'b0};
        mem_data_r <= half_fmt(head_s.data[15:0]);
        hi_data_r  <= half_fmt(head_s.data[31:16]);
      end else if (load_hi_s) begin
        mem_addr_r[0] <= 1'b1;
        mem_data_r    <= hi_data_r;
      end else begin
        mem_addr_r <= mem_addr_r;
        mem_data_r <= mem_data_r;
      end
    end
  end

  // Sticky drop flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r | (hit_s && fifo_full_s);
    end
  end

  assign mem_valid = mem_valid_r;
  assign mem_addr  = mem_addr_r;
  assign mem_data  = mem_data_r;
  assign overflow  = overflow_r;
  assign busy      = (fifo_count_s != FIFO_CW'(0)) || (state_r != IDLE);

endmodule

// File: tb/tb_bridge_psram_writer.sv
// Scoreboard bench for bridge_psram_writer: expected halfwords are queued
// when bridge writes are driven and compared at each request handshake.
module tb_bridge_psram_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bridge_wr;
  logic [31:0] bridge_addr;
  logic [31:0] bridge_wr_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [22:0] mem_addr;
  logic [15:0] mem_data;
  logic        busy;
  logic        overflow;

  int          total = 0;
  int          bad = 0;
  int          hs_count = 0;
  int          base;
  bit          seen;
  logic [38:0] sb[$];
  logic        stall_prev = 1'b0;
  logic [22:0] stall_addr;
  logic [15:0] stall_data;

  always #5 clk = ~clk;

  bridge_psram_writer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bridge_wr      (bridge_wr),
    .bridge_addr    (bridge_addr),
    .bridge_wr_data (bridge_wr_data),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .busy           (busy),
    .overflow       (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_half(input logic [15:0] h);
`ifdef BRIDGE_WR_BYTESWAP_EN
    return {h[7:0], h[15:8]};
`else
    return h;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives a one-cycle write; when it should be accepted, queues both halves.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit accept);
    bridge_wr      = 1'b1;
    bridge_addr    = a;
    bridge_wr_data = d;
    if (accept) begin
      sb.push_back({a[23:2], 1'b0, exp_half(d[15:0])});
      sb.push_back({a[23:2], 1'b1, exp_half(d[31:16])});
    end
    step(1);
    bridge_wr = 1'b0;
  endtask

  task automatic drain(input string tag);
    int i = 0;
    while ((sb.size() != 0 || busy) && i < 300) begin
      step(1);
      i++;
    end
    chk({tag, "_left"}, sb.size(), 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Handshake monitor and stall-stability checker.
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_addr", mem_addr, stall_addr);
        chk("stall_data", mem_data, stall_data);
      end
      if (mem_valid && mem_ready) begin
        hs_count <= hs_count + 1;
        chk("hw_pending", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          chk("hw_addr", mem_addr, sb[0][38:16]);
          chk("hw_data", mem_data, sb[0][15:0]);
          void'(sb.pop_front());
        end
      end
      stall_prev <= mem_valid && !mem_ready;
      stall_addr <= mem_addr;
      stall_data <= mem_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    bridge_wr      = 1'b0;
    bridge_addr    = 32'h0;
    bridge_wr_data = 32'h0;
    mem_ready      = 1'b1;
    step(2);
    chk("rst_valid", mem_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    step(1);

    // Single write: valid appears two cycles after the strobe.
    wr(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    chk("lat_n1_valid", mem_valid, 0);
    step(1);
    chk("lat_valid", mem_valid, 1);
    chk("lat_lo_addr", mem_addr, 23'h000008);
    chk("lat_lo_data", mem_data, exp_half(16'hBEEF));
    step(1);
    chk("lat_hi_valid", mem_valid, 1);
    chk("lat_hi_addr", mem_addr, 23'h000009);
    chk("lat_hi_data", mem_data, exp_half(16'hDEAD));
    step(1);
    chk("single_valid_off", mem_valid, 0);
    chk("single_busy_off", busy, 0);

    // Outside the window: nothing happens.
    wr(32'h1000_0000, 32'hCAFE_F00D, 1'b0);
    seen = 1'b0;
    repeat (10) begin
      if (mem_valid || busy) seen = 1'b1;
      step(1);
    end
    chk("miss_quiet", seen, 0);

    // Top of the window lands on die 1.
    wr(32'h00FF_FFFC, 32'h1234_5678, 1'b1);
    drain("edge");

    // Ready toggling every cycle.
    for (int i = 0; i < 4; i++) begin
      mem_ready = ~mem_ready;
      wr(32'h0000_0100 + (32'(i) << 2), $urandom, 1'b1);
    end
    for (int i = 0; i < 40; i++) begin
      mem_ready = ~mem_ready;
      step(1);
    end
    mem_ready = 1'b1;
    drain("toggle");

    // Overflow: one word parked in LO, then five writes into a depth-4 FIFO.
    mem_ready = 1'b0;
    wr(32'h0000_0200, 32'hA0A0_0000, 1'b1);
    step(2);
    chk("ovf_parked", mem_valid, 1);
    for (int i = 0; i < 5; i++) begin
      wr(32'h0000_0204 + (32'(i) << 2), 32'hB000_0000 + 32'(i), (i < 4));
      if (i == 3) chk("ovf_before", overflow, 0);
    end
    chk("ovf_set", overflow, 1);
    base = hs_count;
    mem_ready = 1'b1;
    drain("ovf");
    chk("ovf_hw_count", hs_count - base, 10);
    chk("ovf_sticky", overflow, 1);

    // Reset while in HI with two entries queued.
    mem_ready = 1'b0;
    wr(32'h0000_0300, 32'h1111_2222, 1'b1);
    wr(32'h0000_0304, 32'h3333_4444, 1'b1);
    wr(32'h0000_0308, 32'h5555_6666, 1'b1);
    chk("mid_lo_valid", mem_valid, 1);
    mem_ready = 1'b1;
    step(1);
    mem_ready = 1'b0;
    chk("mid_in_hi", mem_addr[0], 1);
    reset_n        = 1'b0;
    bridge_wr      = 1'b1;
    bridge_addr    = 32'h0000_0400;
    bridge_wr_data = 32'h7777_8888;
    step(1);
    reset_n   = 1'b1;
    bridge_wr = 1'b0;
    sb.delete();
    chk("mid_rst_valid", mem_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovf", overflow, 0);
    mem_ready = 1'b1;
    base = hs_count;
    step(12);
    chk("mid_rst_no_issue", hs_count - base, 0);
    chk("mid_rst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
